// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned multiplier / divider.
// One multiplier bit (shift-add) or one quotient bit (restoring division)
// is resolved per clock, so every operation takes exactly WIDTH iterations
// regardless of operand values, including a zero divisor.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    // hi_q: upper product half (multiply) or partial remainder (divide).
    // lo_q: multiplier being shifted out (multiply) or dividend shifting
    //       out while quotient bits shift in (divide).
    // opnd_q: multiplicand (multiply) or divisor (divide).
    logic [WIDTH:0]   hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             last_iter;

    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum   = hi_q + {1'b0, (lo_q[0] ? opnd_q : {WIDTH{1'b0}})};
        div_shift = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (op_q[1] == 1'b0) begin
            // Product {hi,lo} shifts right; the sum's LSB enters lo's MSB.
            step_hi = {1'b0, mul_sum[WIDTH:1]};
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            // A zero divisor always "fits", giving all-ones quotient and
            // leaving the dividend as remainder without special casing.
            step_hi = div_ge ? div_diff : div_shift;
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    // Next-state and datapath update for IDLE / BUSY / DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opnd_d   = opnd_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                    op_d    = op;
                    hi_d    = '0;
                    if (op[1] == 1'b0) begin
                        opnd_d = srcA;
                        lo_d   = srcB;
                    end else begin
                        opnd_d = srcB;
                        lo_d   = srcA;
                    end
                end
            end
            BUSY: begin
                if (flush) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    hi_d  = step_hi;
                    lo_d  = step_lo;
                    if (last_iter) begin
                        state_d  = DONE;
                        // op[0] picks the upper half / remainder (hi)
                        // versus the lower half / quotient (lo).
                        result_d = op_q[0] ? step_hi[WIDTH-1:0] : step_lo;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q == BUSY);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: stimulus pushes expected results computed
// with plain arithmetic; a negedge monitor pops and compares on each done.
module tb_muldiv_seq;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   op = 2'd0;
    logic [W-1:0] srcA = '0;
    logic [W-1:0] srcB = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    typedef struct packed {
        logic [W-1:0] res;
        int           due;
        logic [1:0]   op;
    } exp_t;

    exp_t         sb[$];
    exp_t         e;
    logic [W-1:0] held = '0;
    logic [W-1:0] last_exp = '0;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .srcA   (srcA),
        .srcB   (srcB),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        chk_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    function automatic logic [W-1:0] ref_model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        case (o)
            2'd0:    return p[W-1:0];
            2'd1:    return p[2*W-1:W];
            2'd2:    return (b == '0) ? {W{1'b1}} : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

    // Monitor: compare each done against the scoreboard; result must hold otherwise.
    always @(negedge clk) begin
        if (rst) begin
            held = '0;
        end else if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1'b1, 1'b0);
                held = result;
            end else begin
                e = sb.pop_front();
                check("result", result, e.res);
                check("latency", W'(cyc), W'(e.due));
                check("busy_in_done", busy, 1'b0);
                $display("txn op=%0d result=0x%08h expected=0x%08h cycle=%0d", e.op, result, e.res, cyc);
                held = e.res;
            end
        end else begin
            check("result_held", result, held);
        end
    end

    // Issue one operation; optionally poke start mid-op and during DONE.
    task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit fl, input bit poke, input bit sync_neg);
        bit finished;
        if (sync_neg) @(negedge clk);
        op = o; srcA = a; srcB = b; start = 1'b1; flush = fl;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        sb.push_back('{res: ref_model(o, a, b), due: cyc + W, op: o});
        last_exp = ref_model(o, a, b);
        check("busy_after_start", busy, 1'b1);
        if (poke) begin
            repeat (5) @(negedge clk);
            op = ~o; srcA = $urandom; srcB = $urandom; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        finished = 1'b0;
        for (int i = 0; i < W + 8; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() != 0 && !done) check("busy_during", busy, 1'b1);
            start = poke && done;
            if (sb.size() == 0 && !busy && !done) begin
                finished = 1'b1;
                break;
            end
        end
        start = 1'b0;
        if (!finished) begin
            check("timeout", 1'b1, 1'b0);
            sb.delete();
        end
        @(negedge clk);
        #1;
        check("idle_after_op", busy, 1'b0);
    endtask

    initial begin
        logic [1:0]   o;
        logic [W-1:0] a, b;
        #2 rst = 1'b1;
        #1;
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, '0);
        repeat (3) @(negedge clk);

        // First start on the first edge after reset release.
        rst = 1'b0;
        do_op(2'd0, 7, 6, 1'b0, 1'b0, 1'b0);
        do_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
        do_op(2'd2, 100, 7, 1'b0, 1'b0, 1'b1);
        do_op(2'd3, 100, 7, 1'b0, 1'b0, 1'b1);
        do_op(2'd2, 3, 9, 1'b0, 1'b0, 1'b1);
        do_op(2'd3, 3, 9, 1'b0, 1'b0, 1'b1);
        do_op(2'd2, 32'h1234_5678, 0, 1'b0, 1'b0, 1'b1);
        do_op(2'd3, 32'h1234_5678, 0, 1'b0, 1'b1, 1'b1);

        // Flush mid-op: ignored start at E5, flush sampled at E11, no done.
        @(negedge clk);
        op = 2'd0; srcA = 5; srcB = 5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 2'd2; srcA = 9; srcB = 3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("busy_before_flush", busy, 1'b1);
        @(negedge clk) flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        check("busy_after_flush", busy, 1'b0);
        repeat (40) @(negedge clk);
        #1;
        check("flush_no_done", done, 1'b0);
        check("flush_result", result, last_exp);
        do_op(2'd1, 32'h8000_0001, 32'h0000_0003, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-op (counter = 15).
        @(negedge clk);
        op = 2'd0; srcA = 32'hDEAD_BEEF; srcB = 32'h0000_1234; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_result", result, '0);
        @(negedge clk);
        #1 rst = 1'b0;
        repeat (40) @(negedge clk);
        #1 check("post_rst_no_done", done, 1'b0);

        // Flush together with start in IDLE: start wins.
        do_op(2'd0, 123, 456, 1'b1, 1'b0, 1'b1);

        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            case ($urandom_range(0, 3))
                0:       b = '0;
                1:       b = W'($urandom_range(1, 15));
                default: b = W'($urandom);
            endcase
            do_op(o, a, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), 1'b1);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; all values below assume WIDTH=32.
REQ-002 clk  input  1  rising-edge clock; sole clock domain.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 op  input  2  operation: 00 MUL (low word), 01 MULHU (high word, unsigned), 10 DIVU (quotient), 11 REMU (remainder).
REQ-006 srcA  input  WIDTH  multiplicand / dividend (unsigned).
REQ-007 srcB  input  WIDTH  multiplier / divisor (unsigned).
REQ-008 flush  input  1  synchronous abort of an operation in progress.
REQ-009 busy  output  1  high while an operation is in progress (state BUSY).
REQ-010 done  output  1  single-cycle pulse; result valid for the selected op.
REQ-011 result  output  WIDTH  registered result; held until the next completion.

Function
REQ-012 State machine states SHALL be IDLE, BUSY, DONE; busy=1 only in BUSY, done=1 only in DONE.
REQ-013 IDLE: on a clock edge with start=1 SHALL latch op, srcA, srcB, clear the iteration counter, and go to BUSY; start=0 remains in IDLE.
REQ-014 BUSY: each edge SHALL perform exactly one iteration and increment a counter of ceil(log2(WIDTH))+1 bits; after the WIDTH-th iteration SHALL go to DONE.
REQ-015 Multiply (op 0x): shift-add, one multiplier bit per iteration, forming a 2*WIDTH-bit unsigned product; MUL returns bits [WIDTH-1:0], MULHU returns bits [2*WIDTH-1:WIDTH].
REQ-016 Divide (op 1x): restoring division, one quotient bit per iteration, with a WIDTH+1-bit partial remainder; DIVU returns quotient, REMU returns remainder.
REQ-017 Divisor zero SHALL yield quotient all-ones and remainder = srcA, with the same fixed latency (no early exit).
REQ-018 result SHALL be written on the edge that enters DONE and SHALL NOT change at any other time except reset.
REQ-019 DONE: SHALL last exactly one cycle, then go to IDLE; a start in DONE is ignored.
REQ-020 Latency: with start sampled at edge E0, done SHALL be high in the cycle following edge E(WIDTH), i.e. from E32 to E33 for WIDTH=32; back-to-back throughput one operation per WIDTH+2 cycles.
REQ-021 start while BUSY or DONE SHALL be ignored; latched operands SHALL not change.
REQ-022 flush=1 in BUSY SHALL return to IDLE on the next edge, with no done pulse and result unchanged; flush in IDLE/DONE has no effect; flush and start together in IDLE: flush has no effect, start is accepted.
REQ-023 All outputs SHALL come directly from registers or from state decode, with no combinational path from inputs to outputs.

Reset
REQ-024 rst=1 SHALL immediately (asynchronously) force state IDLE, busy=0, done=0, result=0, counter=0, internal operand/accumulator registers=0.
REQ-025 rst asserted mid-operation SHALL discard it; after release, no done pulse until a new start.
REQ-026 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-027 MUL srcA=7, srcB=6, start at E0 -> busy=1 from E0 to E32, done pulse E32-E33, result=0x0000002A.
REQ-028 srcA=srcB=0xFFFFFFFF: MUL -> 0x00000001; MULHU -> 0xFFFFFFFE.
REQ-029 srcA=100, srcB=7: DIVU -> 0x0000000E; REMU -> 0x00000002; srcA=3, srcB=9: DIVU -> 0, REMU -> 3.
REQ-030 srcA=0x12345678, srcB=0: DIVU -> 0xFFFFFFFF, REMU -> 0x12345678, done still at E32-E33.
REQ-031 Start MUL 5*5; at E5 pulse start with op=DIVU; at E10 assert flush -> start ignored, busy=0 after E11, no done, result keeps prior value; next start works normally.
REQ-032 Assert rst between edges mid-operation (counter=15) -> busy, done, result go 0 without a clock edge; after release, done stays 0 until a new start completes.
